fifo4_reader: RTL and testbench

FIFO4_READER -- requirements
Module: fifo4_reader

---
 rtl/fifo4_pkg.sv | 30 +++
 rtl/sync_ff.sv | 25 ++
 rtl/fifo4_reader.sv | 133 +++++++++++++
 tb/tb_fifo4_reader.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo4_pkg.sv
// fifo4_pkg: shared definitions for the self-timed FIFO reader.
//   state_t        - reader FSM state encoding
//   *_MIN / *_MAX  - legal ranges of the fifo4_reader parameters
//   clamp()        - folds an out-of-range parameter into its legal range
package fifo4_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_PULSE   = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_ERROR   = 3'd4
  } state_t;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int PULSE_MIN_MIN   = 1;
  localparam int PULSE_MIN_MAX   = 15;
  localparam int SETTLE_MIN      = 1;
  localparam int SETTLE_MAX      = 15;
  localparam int TIMEOUT_MIN     = 8;
  localparam int TIMEOUT_MAX     = 255;

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// sync_ff: multi-flop synchronizer for a single asynchronous level.
//   clk   - destination clock
//   rst_n - asynchronous active-low reset; all flops load RST_VAL
//   d     - asynchronous input level
//   q     - synchronized level, STAGES clocks behind d
module sync_ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= {STAGES{RST_VAL}};
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/fifo4_reader.sv
// fifo4_reader: pulls words out of a self-timed 4-stage FIFO and presents
// them as a valid/ready stream through a 2-entry in-order buffer.
//   clk, clrn    - clock, asynchronous active-low reset
//   fifo_empty   - asynchronous empty flag (1 = output stage empty)
//   fifo_dout    - asynchronous output-stage data
//   fifo_read    - registered pop strobe, high only in PULSE
//   m_valid      - stream word present (occupancy != 0)
//   m_ready      - downstream accept
//   m_data       - stream word (buffer head)
//   occupancy    - words in the buffer (0..2)
//   timeout_err  - sticky: empty did not rise within TIMEOUT cycles of a read
//   fsm_state    - current FSM state, for observation
//
// Stream handshake: a word transfers on a rising edge where m_valid=1 and
// m_ready=1; m_data is held stable while m_valid=1 and m_ready=0, and
// m_valid never drops without a transfer (except on reset).
module fifo4_reader
  import fifo4_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_MIN   = 2,
  parameter int SETTLE      = 3,
  parameter int TIMEOUT     = 64
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       fifo_read,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic [1:0] occupancy,
  output logic       timeout_err,
  output state_t     fsm_state
);

  localparam int SYNC_N    = clamp(SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
  localparam int PULSE_N   = clamp(PULSE_MIN, PULSE_MIN_MIN, PULSE_MIN_MAX);
  localparam int SETTLE_N  = clamp(SETTLE, SETTLE_MIN, SETTLE_MAX);
  localparam int TIMEOUT_N = clamp(TIMEOUT, TIMEOUT_MIN, TIMEOUT_MAX);

  localparam logic [8:0] PULSE_W   = 9'(PULSE_N);
  localparam logic [8:0] SETTLE_W  = 9'(SETTLE_N);
  localparam logic [8:0] TIMEOUT_W = 9'(TIMEOUT_N);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [8:0]  elapsed;
  logic        empty_s;
  logic        push, pop;
  logic [1:0]  occ_after;
  logic        head, tail;
  logic [7:0]  mem [2];

  // Reset value 1 keeps the reader idle until a real "not empty" has
  // crossed every stage after reset release.
  sync_ff #(.STAGES(SYNC_N), .RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (clrn),
    .d     (fifo_empty),
    .q     (empty_s)
  );

  assign pop       = m_valid && m_ready;
  assign push      = (state_q == ST_CAPTURE);
  assign occ_after = occupancy - {1'b0, pop};
  // Cycles spent in the current state including this one.
  assign elapsed   = {1'b0, cnt_q} + 9'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_s && occ_after < 2'd2) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: state_d = ST_PULSE;
      ST_PULSE: begin
        if (empty_s && elapsed >= PULSE_W)        state_d = ST_SETTLE;
        else if (!empty_s && elapsed >= TIMEOUT_W) state_d = ST_ERROR;
        else                                       cnt_d   = elapsed[7:0];
      end
      ST_SETTLE: begin
        if (elapsed >= SETTLE_W) state_d = ST_IDLE;
        else                     cnt_d   = elapsed[7:0];
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_IDLE;
    endcase
  end

  // fifo_read comes straight from a flop so the FIFO never sees a glitch.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      fifo_read   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fifo_read <= (state_d == ST_PULSE);
      if (state_d == ST_ERROR) timeout_err <= 1'b1;
    end
  end

  // Tail is computed from the pre-pop head, so a capture coinciding with a
  // pop at occupancy 1 lands behind the departing word.
  assign tail = head ^ occupancy[0];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      mem[0]    <= 8'h00;
      mem[1]    <= 8'h00;
      head      <= 1'b0;
      occupancy <= 2'd0;
    end else begin
      if (push) mem[tail] <= fifo_dout;
      if (pop)  head      <= ~head;
      case ({push, pop})
        2'b10:   occupancy <= occupancy + 2'd1;
        2'b01:   occupancy <= occupancy - 2'd1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  assign m_valid   = (occupancy != 2'd0);
  assign m_data    = mem[head];
  assign fsm_state = state_q;

endmodule

// File: tb/tb_fifo4_reader.sv
// tb_fifo4_reader: directed bench for fifo4_reader with a behavioural model
// of the self-timed FIFO and a scoreboard of expected stream words.
module tb_fifo4_reader;
  import fifo4_pkg::*;

  localparam int SYNC_STAGES = 2;
  localparam int PULSE_MIN   = 2;
  localparam int TIMEOUT     = 64;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clrn;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       fifo_read;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [1:0] occupancy;
  logic       timeout_err;
  state_t     fsm_state;

  fifo4_reader #(
    .SYNC_STAGES (SYNC_STAGES),
    .PULSE_MIN   (PULSE_MIN),
    .SETTLE      (3),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk         (clk),
    .clrn        (clrn),
    .fifo_empty  (fifo_empty),
    .fifo_dout   (fifo_dout),
    .fifo_read   (fifo_read),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .occupancy   (occupancy),
    .timeout_err (timeout_err),
    .fsm_state   (fsm_state)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];

  // FIFO model state
  logic [7:0] src_mem [0:31];
  int         src_wr    = 0;
  int         src_rd    = 0;
  bit         stuck     = 1'b0;
  bit         popped    = 1'b0;
  bit         prev_read = 1'b0;
  int         pulse_len = 0;
  int         pulses    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Self-timed FIFO: a read empties the output stage (unless stuck); when
  // the read strobe falls the next stored word moves to the output stage.
  task automatic model_update();
    if (fifo_read === 1'b1) begin
      if (!popped) begin
        popped = 1'b1;
        if (!stuck) src_rd++;
      end
      fifo_empty = stuck ? 1'b0 : 1'b1;
    end else begin
      popped = 1'b0;
      if (src_rd < src_wr) begin
        fifo_empty = 1'b0;
        fifo_dout  = src_mem[src_rd];
      end else begin
        fifo_empty = 1'b1;
      end
    end
    if (!clrn) begin
      prev_read = 1'b0;
      pulse_len = 0;
    end else begin
      if (fifo_read === 1'b1) begin
        if (!prev_read) pulses++;
        pulse_len++;
      end else if (prev_read) begin
        chk("pulse_len_min", 32'(pulse_len >= PULSE_MIN), 32'd1);
        pulse_len = 0;
      end
      prev_read = (fifo_read === 1'b1);
    end
  endtask

  task automatic load(input logic [7:0] w);
    src_mem[src_wr] = w;
    src_wr++;
    exp_q.push_back(w);
    model_update();
  endtask

  // Called at a falling edge: scores the transfer the next rising edge
  // performs, advances one cycle, then updates the FIFO model.
  task automatic tick();
    logic [7:0] expv;
    if (m_valid === 1'b1 && m_ready === 1'b1) begin
      chk("sb_word_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        expv = exp_q.pop_front();
        chk("m_data", 32'(m_data), 32'(expv));
      end
    end
    @(posedge clk);
    @(negedge clk);
    model_update();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    int base;

    clrn       = 1'b0;
    m_ready    = 1'b0;
    fifo_empty = 1'b1;
    fifo_dout  = 8'h00;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_fifo_read", 32'(fifo_read), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'h00);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    chk("rst_state", 32'(fsm_state), 32'(ST_IDLE));

    clrn = 1'b1;
    repeat (4) tick();

    // single word
    base    = pulses;
    m_ready = 1'b1;
    load(8'hA5);
    n = 0;
    while (m_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("single_latency", 32'(n), 32'(SYNC_STAGES + 2));
    chk("single_data", 32'(m_data), 32'hA5);
    tick();
    chk("single_valid_one_cycle", 32'(m_valid), 32'd0);
    repeat (10) tick();
    chk("single_pulses", 32'(pulses - base), 32'd1);

    // burst of four
    base = pulses;
    for (int i = 1; i <= 4; i++) load(8'(i));
    drain(200);
    repeat (10) tick();
    chk("burst_pulses", 32'(pulses - base), 32'd4);
    chk("burst_occupancy", 32'(occupancy), 32'd0);

    // backpressure
    m_ready = 1'b0;
    for (int i = 5; i <= 8; i++) load(8'(i));
    repeat (60) tick();
    chk("bp_occupancy", 32'(occupancy), 32'd2);
    chk("bp_fifo_read", 32'(fifo_read), 32'd0);
    chk("bp_words_left", 32'(src_wr - src_rd), 32'd2);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_hold_data", 32'(m_data), 32'h05);
    end
    m_ready = 1'b1;
    drain(300);
    repeat (10) tick();

    // capture coinciding with a pop at occupancy 1
    m_ready = 1'b0;
    load(8'h09);
    n = 0;
    while (occupancy !== 2'd1 && n < 30) begin
      tick();
      n++;
    end
    chk("sim_first_held", 32'(occupancy), 32'd1);
    load(8'h0A);
    n = 0;
    while (fsm_state !== ST_CAPTURE && n < 40) begin
      tick();
      n++;
    end
    chk("sim_in_capture", 32'(fsm_state), 32'(ST_CAPTURE));
    m_ready = 1'b1;
    tick();
    chk("sim_occ_hold", 32'(occupancy), 32'd1);
    chk("sim_order", 32'(m_data), 32'h0A);
    drain(20);
    repeat (10) tick();

    // reset mid-PULSE
    load(8'h0B);
    n = 0;
    while (fifo_read !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk("rmid_in_pulse", 32'(fifo_read), 32'd1);
    clrn = 1'b0;
    #1;
    chk("rmid_fifo_read", 32'(fifo_read), 32'd0);
    chk("rmid_occupancy", 32'(occupancy), 32'd0);
    chk("rmid_m_valid", 32'(m_valid), 32'd0);
    chk("rmid_timeout_err", 32'(timeout_err), 32'd0);
    exp_q.delete();
    load(8'h0C);
    tick();
    clrn = 1'b1;
    n = 0;
    while (m_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("rmid_first_latency", 32'(n), 32'(SYNC_STAGES + 2));
    chk("rmid_first_data", 32'(m_data), 32'h0C);
    drain(20);
    repeat (10) tick();

    // empty stuck low after the read
    m_ready = 1'b0;
    stuck   = 1'b1;
    load(8'h0D);
    n = 0;
    while (fifo_read !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk("stuck_in_pulse", 32'(fifo_read), 32'd1);
    base = pulses;
    n = 0;
    while (fifo_read === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    chk("stuck_pulse_cycles", 32'(n), 32'(TIMEOUT));
    chk("stuck_timeout_err", 32'(timeout_err), 32'd1);
    chk("stuck_fifo_read", 32'(fifo_read), 32'd0);
    chk("stuck_state", 32'(fsm_state), 32'(ST_ERROR));
    chk("stuck_m_valid", 32'(m_valid), 32'd1);
    chk("stuck_m_data", 32'(m_data), 32'h0D);
    m_ready = 1'b1;
    drain(20);
    repeat (20) tick();
    chk("stuck_state_sticky", 32'(fsm_state), 32'(ST_ERROR));
    chk("stuck_err_sticky", 32'(timeout_err), 32'd1);
    chk("stuck_no_more_reads", 32'(pulses - base), 32'd0);
    chk("stuck_drained", 32'(occupancy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
